// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers and the InvMixColumns engine FSM encoding.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } imc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by a constant whose set bits all lie in [3:0]: XOR of an xtime chain.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = b;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] gf_mul09(input logic [7:0] b);
        return gf_mul(b, 4'h9);
    endfunction

    function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
        return gf_mul(b, 4'hb);
    endfunction

    function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
        return gf_mul(b, 4'hd);
    endfunction

    function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
        return gf_mul(b, 4'he);
    endfunction

    // Column c of a 128-bit state sits at bits [127-32c -: 32].
    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
        logic [31:0] r;
        case (c)
            2'd0:    r = s[127:96];
            2'd1:    r = s[95:64];
            2'd2:    r = s[63:32];
            default: r = s[31:0];
        endcase
        return r;
    endfunction

    function automatic logic [127:0] set_col(input logic [127:0] s, input logic [1:0] c,
                                             input logic [31:0] v);
        logic [127:0] r;
        r = s;
        case (c)
            2'd0:    r[127:96] = v;
            2'd1:    r[95:64]  = v;
            2'd2:    r[63:32]  = v;
            default: r[31:0]   = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inv_mixcolumn32.sv
// Combinational InvMixColumns on one 32-bit column; row 0 is the most significant byte.
module inv_mixcolumn32
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] b0, b1, b2, b3;

    assign b0 = col_in[31:24];
    assign b1 = col_in[23:16];
    assign b2 = col_in[15:8];
    assign b3 = col_in[7:0];

    // Each output row uses the same 0e/0b/0d/09 pattern on a rotated byte order.
    assign col_out[31:24] = gf_mul0e(b0) ^ gf_mul0b(b1) ^ gf_mul0d(b2) ^ gf_mul09(b3);
    assign col_out[23:16] = gf_mul0e(b1) ^ gf_mul0b(b2) ^ gf_mul0d(b3) ^ gf_mul09(b0);
    assign col_out[15:8]  = gf_mul0e(b2) ^ gf_mul0b(b3) ^ gf_mul0d(b0) ^ gf_mul09(b1);
    assign col_out[7:0]   = gf_mul0e(b3) ^ gf_mul0b(b0) ^ gf_mul0d(b1) ^ gf_mul09(b2);

endmodule

// File: rtl/inv_mixcolumn_seq.sv
// Sequential AES InvMixColumns: accepts a 128-bit state, transforms COLS_PER_CYCLE
// columns per clock in place, then holds the result until downstream takes it.
module inv_mixcolumn_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    // Handshake: a transfer happens only on a rising edge where valid and ready are
    // both high; ready/valid come straight from the state register, and out_data
    // holds steady while out_valid is high and out_ready is low.

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("inv_mixcolumn_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

    imc_state_e   state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [1:0]   col_idx_q, col_idx_d;

    logic [32*COLS_PER_CYCLE-1:0] col_out_flat;

    // Lane k always works on column col_idx+k of the work register.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        logic [1:0]  sel;
        logic [31:0] lane_in;

        assign sel     = col_idx_q + 2'(k);
        assign lane_in = get_col(work_q, sel);

        inv_mixcolumn32 u_col (
            .col_in  (lane_in),
            .col_out (col_out_flat[32*k +: 32])
        );
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        col_idx_d = col_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d    = in_data;
                    col_idx_d = 2'd0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    work_d = set_col(work_d, col_idx_q + 2'(k), col_out_flat[32*k +: 32]);
                end
                col_idx_d = col_idx_q + COL_STEP;
                if (col_idx_q == LAST_IDX) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            work_q    <= '0;
            col_idx_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            col_idx_q <= col_idx_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign out_data  = work_q;

endmodule

// File: tb/tb_inv_mixcolumn_seq.sv
// Bench for inv_mixcolumn_seq: three instances (1, 2 and 4 columns per clock) share
// the input side; each has its own output side.
module tb_inv_mixcolumn_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic         in_ready_v  [3];
    logic         out_valid_v [3];
    logic         busy_v      [3];
    logic [127:0] out_data_v  [3];

    int n_err    = 0;
    int n_checks = 0;

    localparam logic [127:0] FULL_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] FULL_EXP = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] B2B_IN   = 128'h4d7ebdf8_d5d5d7d6_01010101_c6c6c6c6;
    localparam logic [127:0] B2B_EXP  = 128'h2d26314c_d4d4d4d5_01010101_c6c6c6c6;

    always #5 clk = ~clk;

    inv_mixcolumn_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .in_data(in_data), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .out_data(out_data_v[0]), .busy(busy_v[0])
    );
    inv_mixcolumn_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .in_data(in_data), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .out_data(out_data_v[1]), .busy(busy_v[1])
    );
    inv_mixcolumn_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .in_data(in_data), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .out_data(out_data_v[2]), .busy(busy_v[2])
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Forward MixColumns reference used to build round-trip stimulus.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        return {fwd_col(s[127:96]), fwd_col(s[95:64]), fwd_col(s[63:32]), fwd_col(s[31:0])};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entry: at a negedge with all instances idle. Sends one block to all three,
    // checks latency and data per instance, then drains with one out_ready pulse.
    task automatic run_block(input string name, input logic [127:0] din, input logic [127:0] exp);
        int  lat  [3];
        bit  seen [3];
        int  exp_lat [3];
        exp_lat = '{4, 2, 1};
        for (int k = 0; k < 3; k++) begin
            seen[k] = 1'b0;
            lat[k]  = -1;
        end
        in_valid  = 1'b1;
        in_data   = din;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        for (int t = 0; t <= 12; t++) begin
            for (int k = 0; k < 3; k++) begin
                if (!seen[k] && out_valid_v[k]) begin
                    seen[k] = 1'b1;
                    lat[k]  = t;
                end
            end
            if (seen[0] && seen[1] && seen[2]) break;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            check_int($sformatf("%s_lat%0d", name, k), lat[k], exp_lat[k]);
            check($sformatf("%s_data%0d", name, k), out_data_v[k], exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic wait_out0(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (out_valid_v[0]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        string        name;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [6];

    logic [127:0] exp_q [$];

    initial begin
        bit           ok;
        int           accepted;
        int           n_out;
        int           t_out [2];
        logic [127:0] s;
        logic [127:0] got;

        vecs[0] = '{"single_col", 128'h8e4da1bc_00000000_00000000_00000000,
                                  128'hdb135345_00000000_00000000_00000000};
        vecs[1] = '{"full_block", FULL_IN, FULL_EXP};
        vecs[2] = '{"b2b_block",  B2B_IN, B2B_EXP};
        vecs[3] = '{"zero",       128'h0, 128'h0};
        vecs[4] = '{"all_ff",     {4{32'hffffffff}}, {4{32'hffffffff}}};
        vecs[5] = '{"col_swap",   128'h01010101_8e4da1bc_c6c6c6c6_9fdc589d,
                                  128'h01010101_db135345_c6c6c6c6_f20a225c};

        // clock/reset
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        do_reset();

        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_in_ready%0d", k),  {127'b0, in_ready_v[k]},  128'd1);
            check($sformatf("rst_out_valid%0d", k), {127'b0, out_valid_v[k]}, 128'd0);
            check($sformatf("rst_busy%0d", k),      {127'b0, busy_v[k]},      128'd0);
            check($sformatf("rst_out_data%0d", k),  out_data_v[k],            128'd0);
        end

        // table-driven vectors across all three column widths
        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i].name, vecs[i].din, vecs[i].exp);
            check($sformatf("%s_idle_after", vecs[i].name), {127'b0, in_ready_v[0]}, 128'd1);
        end

        // backpressure: hold out_ready low for 10 cycles, poke in_valid once
        in_valid  = 1'b1;
        in_data   = FULL_IN;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out0(ok);
        check_int("bp_out_valid_rise", int'(ok), 1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_valid_%0d", i), {127'b0, out_valid_v[0]}, 128'd1);
            check($sformatf("bp_data_%0d", i),  out_data_v[0], FULL_EXP);
            check($sformatf("bp_in_ready_%0d", i), {127'b0, in_ready_v[0]}, 128'd0);
            in_valid = (i == 3);
            in_data  = 128'h11223344_55667788_99aabbcc_ddeeff00;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", {127'b0, out_valid_v[0]}, 128'd0);
        check("bp_release_ready", {127'b0, in_ready_v[0]},  128'd1);
        @(negedge clk);
        check("bp_no_second_valid", {127'b0, out_valid_v[0]}, 128'd0);
        check("bp_no_second_busy",  {127'b0, busy_v[0]},      128'd0);

        // back-to-back with in_valid held high (1 column per clock instance)
        exp_q.push_back(B2B_EXP);
        exp_q.push_back(FULL_EXP);
        accepted  = 0;
        n_out     = 0;
        in_valid  = 1'b1;
        in_data   = B2B_IN;
        out_ready = 1'b1;
        for (int t = 0; t < 40 && n_out < 2; t++) begin
            if (out_valid_v[0]) begin
                got = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                check($sformatf("b2b_out%0d", n_out), out_data_v[0], got);
                t_out[n_out] = t;
                n_out++;
            end
            if (in_valid && in_ready_v[0]) accepted++;
            @(negedge clk);
            if (accepted == 1) in_data = FULL_IN;
            else if (accepted >= 2) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_int("b2b_outputs", n_out, 2);
        if (n_out == 2) begin
            check_int("b2b_first_time", t_out[0], 5);
            check_int("b2b_spacing", t_out[1] - t_out[0], 6);
        end
        do_reset();

        // reset in the middle of BUSY at col_idx=2
        in_valid = 1'b1;
        in_data  = FULL_IN;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy_before_rst", {127'b0, busy_v[0]}, 128'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mid_rst_in_ready%0d", k),  {127'b0, in_ready_v[k]},  128'd1);
            check($sformatf("mid_rst_out_valid%0d", k), {127'b0, out_valid_v[k]}, 128'd0);
            check($sformatf("mid_rst_out_data%0d", k),  out_data_v[k],            128'd0);
        end
        run_block("after_abort", B2B_IN, B2B_EXP);

        // round trip through the forward transform
        for (int i = 0; i < 1000; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            run_block($sformatf("rt%0d", i), fwd_mix(s), s);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
